colour_sequencer: RTL and testbench
===================================

# colour_sequencer

Parametrised successor to the fixed four-colour flasher: it plays back the first `round_len` entries of a stored colour sequence as timed on/off flashes on a one-hot display bus, under its own state machine. The player's live input is overlaid on the display bus. It sits between the game FSM, which supplies the sequence, round length and start/abort, and the LED driver, which consumes `disp_o`. Playback timing is generated internally from tick counters instead of an external flash clock.

## Interface
- `NUM_COLOURS`, default 4: number of colours/LEDs; minimum 2.
- `SEQ_DEPTH`, default 32: number of sequence entries.
- `ON_TICKS`, default 4: cycles each colour is lit; minimum 1.
- `OFF_TICKS`, default 2: blank cycles after each colour; minimum 1.
- `flash_clk  input  1`: single clock; all state changes on its rising edge.
- `reset  input  1`: synchronous, active-high.
- `start  input  1`: request playback; sampled only in IDLE.
- `abort  input  1`: stop playback immediately.
- `round_len  input  $clog2(SEQ_DEPTH)+1`: number of entries to play.
- `segment  input  SEQ_DEPTH x CW`: colour codes, with CW = $clog2(NUM_COLOURS)+1; entry 0 plays first.
- `input_en  input  1`: allows the player overlay.
- `player_input  input  NUM_COLOURS`: live one-hot or multi-hot player buttons.
- `disp_o  output  NUM_COLOURS`: display bus.
- `busy  output  1`: high in ON and OFF.
- `done  output  1`: one-cycle pulse when playback completes.
- `step_o  output  $clog2(SEQ_DEPTH)`: index of the entry currently playing.

## Operation
- FSM states: IDLE, ON, OFF, DONE. Reset sends the FSM to IDLE.
- On reset: `flash_q`=0, `step_o`=0, tick counter=0, `busy`=0, `done`=0, and `disp_o`=0. `disp_o` is forced to 0 combinationally while `reset` is high.
- IDLE with `start`=1:
  - `round_len`=0: go to DONE and light nothing.
  - Otherwise latch `len` = min(`round_len`, SEQ_DEPTH), set idx=0, tick=0, `flash_q`=decode(`segment[0]`), and go to ON.
- ON: tick increments each cycle. When tick==ON_TICKS-1: `flash_q`=0, tick=0, go to OFF.
- OFF: when tick==OFF_TICKS-1:
  - If idx==len-1: go to DONE.
  - Otherwise: idx+1, `flash_q`=decode(`segment[idx+1]`), go to ON.
- DONE: `done`=1 for exactly this one cycle, then go to IDLE.
- `abort`=1 in any state: next state IDLE, `flash_q`=0, no `done` pulse. Abort takes priority over all other transitions.
- `start` outside IDLE is ignored. `start` and `abort` in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- decode: a code below NUM_COLOURS gives a one-hot bit at position code. Codes at or above NUM_COLOURS give all zeros (blank step, still timed).
- `segment` is sampled at each ON entry, not at start, so the game FSM may append entries during playback.
- `disp_o` = `flash_q` | (`player_input` & {NUM_COLOURS{`input_en`}}). This path is combinational and is never cleared by flashing.
- `step_o` = idx; it holds its last value in DONE and IDLE until the next accepted start.

## Timing
- Start accepted at edge k: colour 0 is visible from cycle k+1.
- Each step lasts ON_TICKS+OFF_TICKS cycles. `busy` is high for len·(ON_TICKS+OFF_TICKS) cycles.
- `done` is high in the cycle immediately after the last OFF cycle.
- Player-input path latency: 0 cycles (combinational).
- Abort at edge k: `disp_o` shows player overlay only from cycle k+1, and `busy`=0.

## Structure
- Shared package `colour_pkg` holds:
  - `NUM_COLOURS_DEFAULT`;
  - the `CW` function/localparam;
  - typedef `seq_state_e` {IDLE, ON, OFF, DONE};
  - the `BLANK` code constant.
- Sub-module `colour_decode` (CW-bit code to NUM_COLOURS one-hot, out-of-range gives 0). It is reused by the input checker.

## Test plan
- Defaults, `segment` = {2,0,3,…}, `round_len`=3, pulse `start` -> `disp_o` = 0100 for 4 cycles, 0 for 2 cycles, then 0001, then 1000; `done` pulses at cycle 19 after start; `busy` is high for 18 cycles.
- `round_len`=0 -> `done` the next cycle; `disp_o` stays 0; `busy` never rises.
- `abort` in the 2nd ON cycle of step 1 -> IDLE next cycle, `flash_q`=0, no `done`; a new `start` replays from step 0.
- `input_en`=1, `player_input`=0010 while colour 3 is lit -> `disp_o`=1010; `input_en`=0 -> `disp_o`=1000.
- Code 5 at step 1 (NUM_COLOURS=4) -> blank for 6 cycles, playback continues; `round_len`=40 with SEQ_DEPTH=32 -> plays 32 steps.
- `reset` asserted mid-ON with `player_input`=1111 -> `disp_o`=0 during reset, IDLE after; `start` pulsed while `busy` -> ignored.

Source files
------------

// File: rtl/colour_pkg.sv
// colour_pkg: definitions shared by the colour sequencer, its decoder and any checker
// that has to interpret colour codes.
//   NUM_COLOURS_DEFAULT - default number of colours/LEDs
//   calc_cw()           - colour code width for a given colour count
//   seq_state_e         - playback FSM states
//   BLANK               - a colour code that always decodes to "no LED"
package colour_pkg;

  localparam int unsigned NUM_COLOURS_DEFAULT = 4;

  // One bit wider than strictly needed so that out-of-range (blank) codes can be encoded.
  function automatic int unsigned calc_cw(input int unsigned num_colours);
    return $clog2(num_colours) + 1;
  endfunction

  localparam int unsigned CW_DEFAULT = calc_cw(NUM_COLOURS_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // All-ones of width calc_cw(n) is at least 2n-1, so it is out of range for any n.
  localparam logic [CW_DEFAULT-1:0] BLANK = '1;

endpackage

// File: rtl/colour_decode.sv
// colour_decode: colour code to one-hot LED vector.
//   i_code   - CW-bit colour code
//   o_onehot - NUM_COLOURS-bit one-hot; all zeros when i_code >= NUM_COLOURS
module colour_decode
  import colour_pkg::*;
#(
  parameter int unsigned NUM_COLOURS = NUM_COLOURS_DEFAULT,
  parameter int unsigned CW          = calc_cw(NUM_COLOURS)
) (
  input  logic [CW-1:0]          i_code,
  output logic [NUM_COLOURS-1:0] o_onehot
);

  // Per-bit equality keeps out-of-range codes at zero without a wide index select.
  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < NUM_COLOURS; i++) begin
      o_onehot[i] = (i_code == CW'(i));
    end
  end

endmodule

// File: rtl/colour_sequencer.sv
// colour_sequencer: plays the first round_len entries of a colour sequence as timed
// on/off flashes on a one-hot display bus, with the player's buttons overlaid.
//   flash_clk    - clock
//   reset        - synchronous active-high reset
//   start        - begin playback (only honoured in IDLE)
//   abort        - stop playback at once, no done pulse
//   round_len    - number of entries to play (clamped to SEQ_DEPTH)
//   segment      - colour codes, entry 0 plays first; sampled at each ON entry
//   input_en     - enables the player overlay
//   player_input - live player buttons
//   disp_o       - display bus: flash | gated player input, zero while reset is high
//   busy         - high in ON and OFF
//   done         - one-cycle pulse after the final OFF phase
//   step_o       - index of the entry being played; holds after playback
module colour_sequencer
  import colour_pkg::*;
#(
  parameter int unsigned NUM_COLOURS = NUM_COLOURS_DEFAULT,
  parameter int unsigned SEQ_DEPTH   = 32,
  parameter int unsigned ON_TICKS    = 4,
  parameter int unsigned OFF_TICKS   = 2,
  localparam int unsigned CW         = calc_cw(NUM_COLOURS),
  localparam int unsigned IW         = $clog2(SEQ_DEPTH),
  localparam int unsigned RW         = IW + 1
) (
  input  logic                         flash_clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [RW-1:0]                round_len,
  input  logic [SEQ_DEPTH-1:0][CW-1:0] segment,
  input  logic                         input_en,
  input  logic [NUM_COLOURS-1:0]       player_input,
  output logic [NUM_COLOURS-1:0]       disp_o,
  output logic                         busy,
  output logic                         done,
  output logic [IW-1:0]                step_o
);

  localparam int unsigned MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

  seq_state_e             r_state, w_state_nxt;
  logic [NUM_COLOURS-1:0] r_flash, w_flash_nxt;
  logic [TW-1:0]          r_tick, w_tick_nxt;
  logic [IW-1:0]          r_idx, w_idx_nxt;
  logic [IW-1:0]          r_last, w_last_nxt;  // len-1, so the final-step compare fits IW bits

  logic [IW-1:0]          w_code_idx;
  logic [NUM_COLOURS-1:0] w_dec;

  // Only two places load a colour: start (entry 0) and OFF->ON (next entry).
  assign w_code_idx = (r_state == OFF) ? r_idx + 1'b1 : '0;

  colour_decode #(
    .NUM_COLOURS (NUM_COLOURS),
    .CW          (CW)
  ) u_decode (
    .i_code   (segment[w_code_idx]),
    .o_onehot (w_dec)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_flash_nxt = r_flash;
    w_tick_nxt  = r_tick;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    if (abort) begin
      w_state_nxt = IDLE;
      w_flash_nxt = '0;
      w_tick_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (round_len == '0) begin
              w_state_nxt = DONE;
            end else begin
              w_last_nxt  = (round_len > RW'(SEQ_DEPTH)) ? IW'(SEQ_DEPTH - 1)
                                                         : IW'(round_len - 1'b1);
              w_idx_nxt   = '0;
              w_tick_nxt  = '0;
              w_flash_nxt = w_dec;
              w_state_nxt = ON;
            end
          end
        end
        ON: begin
          if (r_tick == ON_LAST) begin
            w_flash_nxt = '0;
            w_tick_nxt  = '0;
            w_state_nxt = OFF;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        OFF: begin
          if (r_tick == OFF_LAST) begin
            w_tick_nxt = '0;
            if (r_idx == r_last) begin
              w_state_nxt = DONE;
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_flash_nxt = w_dec;
              w_state_nxt = ON;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge flash_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_flash <= '0;
      r_tick  <= '0;
      r_idx   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flash <= w_flash_nxt;
      r_tick  <= w_tick_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign disp_o = reset ? '0 : (r_flash | (player_input & {NUM_COLOURS{input_en}}));
  assign busy   = (r_state == ON) || (r_state == OFF);
  assign done   = (r_state == DONE);
  assign step_o = r_idx;

endmodule

// File: tb/tb_colour_sequencer.sv
module tb_colour_sequencer;
  import colour_pkg::*;

  localparam int unsigned NC  = 4;
  localparam int unsigned SD  = 32;
  localparam int unsigned ONT = 4;
  localparam int unsigned OFT = 2;
  localparam int unsigned CWL = calc_cw(NC);
  localparam int unsigned IW  = $clog2(SD);
  localparam int unsigned RW  = IW + 1;

  logic                   flash_clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [RW-1:0]          round_len = '0;
  logic [SD-1:0][CWL-1:0] segment = '0;
  logic                   input_en = 1'b0;
  logic [NC-1:0]          player_input = '0;
  logic [NC-1:0]          disp_o;
  logic                   busy;
  logic                   done;
  logic [IW-1:0]          step_o;

  colour_sequencer #(
    .NUM_COLOURS (NC),
    .SEQ_DEPTH   (SD),
    .ON_TICKS    (ONT),
    .OFF_TICKS   (OFT)
  ) dut (
    .flash_clk    (flash_clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .round_len    (round_len),
    .segment      (segment),
    .input_en     (input_en),
    .player_input (player_input),
    .disp_o       (disp_o),
    .busy         (busy),
    .done         (done),
    .step_o       (step_o)
  );

  always #5 flash_clk = ~flash_clk;

  // One expected entry per clock cycle of an active playback.
  typedef struct packed {
    logic [NC-1:0] flash;
    logic          busy;
    logic          done;
    logic [IW-1:0] step;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [IW-1:0] m_step = '0;
  bit            mon_en = 1'b0;
  string         phase = "reset";

  function automatic exp_t mk(logic [NC-1:0] f, logic b, logic d, logic [IW-1:0] s);
    exp_t e;
    e.flash = f;
    e.busy  = b;
    e.done  = d;
    e.step  = s;
    return e;
  endfunction

  // Reference: the whole flash timeline of a round, built from the segment contents.
  task automatic push_round(input int unsigned rlen);
    int unsigned   len;
    logic [NC-1:0] one;
    logic [NC-1:0] dec;
    int unsigned   code;
    one = 1;
    if (rlen == 0) begin
      exp_q.push_back(mk('0, 1'b0, 1'b1, m_step));
    end else begin
      len = (rlen > SD) ? SD : rlen;
      for (int unsigned s = 0; s < len; s++) begin
        code = int'(segment[s]);
        dec  = (code < NC) ? (one << code) : '0;
        for (int unsigned t = 0; t < ONT; t++) exp_q.push_back(mk(dec, 1'b1, 1'b0, IW'(s)));
        for (int unsigned t = 0; t < OFT; t++) exp_q.push_back(mk('0, 1'b1, 1'b0, IW'(s)));
      end
      exp_q.push_back(mk('0, 1'b0, 1'b1, IW'(len - 1)));
    end
  endtask

  // Monitor: compares every cycle against the scoreboard or the idle expectation.
  always @(negedge flash_clk) begin
    exp_t          e;
    logic [NC-1:0] exp_disp;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_step = e.step;
      end else begin
        e = mk('0, 1'b0, 1'b0, m_step);
      end
      exp_disp = reset ? '0 : (e.flash | (player_input & {NC{input_en}}));
      n_checks++;
      if ({disp_o, busy, done, step_o} === {exp_disp, e.busy, e.done, e.step}) begin
        n_pass++;
      end else begin
        $display("FAIL %s t=%0t: disp=%b busy=%b done=%b step=%0d, required disp=%b busy=%b done=%b step=%0d",
                 phase, $time, disp_o, busy, done, step_o, exp_disp, e.busy, e.done, e.step);
      end
    end
  end

  task automatic tick();
    @(posedge flash_clk);
    #1;
  endtask

  task automatic issue_start(input int unsigned rlen);
    round_len = RW'(rlen);
    start = 1'b1;
    tick();
    start = 1'b0;
    push_round(rlen);
  endtask

  task automatic rand_overlay();
    input_en     = 1'($urandom_range(0, 1));
    player_input = NC'($urandom);
  endtask

  // Runs until the scoreboard drains; optional random overlay/ignored starts and an abort.
  task automatic run_round(input bit rnd, input int abort_at);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 400) begin
      if (rnd) begin
        rand_overlay();
        if ($urandom_range(0, 15) == 0) start = 1'b1;
      end
      if (c == abort_at) abort = 1'b1;
      tick();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        exp_q.delete();
      end
      c++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s timeout: %0d entries pending, required 0", phase, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    phase = "idle_overlay";
    input_en = 1'b1;
    player_input = 4'b0110;
    tick();
    input_en = 1'b0;
    tick();

    phase = "basic";
    segment[0] = 2;
    segment[1] = 0;
    segment[2] = 3;
    issue_start(3);
    run_round(1'b0, -1);
    tick();

    phase = "zero_len";
    issue_start(0);
    run_round(1'b0, -1);
    tick();

    phase = "abort";
    issue_start(3);
    run_round(1'b0, 7);
    tick();
    tick();
    phase = "replay";
    issue_start(3);
    run_round(1'b0, -1);

    phase = "overlay";
    segment[0] = 3;
    input_en = 1'b1;
    player_input = 4'b0010;
    issue_start(1);
    tick();
    tick();
    input_en = 1'b0;
    run_round(1'b0, -1);

    phase = "blank";
    segment[0] = 1;
    segment[1] = CWL'(5);
    segment[2] = BLANK;
    segment[3] = 2;
    issue_start(4);
    run_round(1'b0, -1);

    phase = "clamp";
    for (int i = 0; i < SD; i++) segment[i] = CWL'($urandom_range(0, 7));
    issue_start(40);
    run_round(1'b1, -1);

    phase = "append";
    segment[2] = 0;
    round_len = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    segment[2] = 1;  // changed after start, before step 2 is loaded
    push_round(3);
    run_round(1'b0, -1);

    phase = "start_abort";
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();

    phase = "reset_mid";
    issue_start(3);
    tick();
    input_en = 1'b1;
    player_input = 4'b1111;
    reset = 1'b1;
    tick();
    exp_q.delete();
    m_step = '0;
    tick();
    reset = 1'b0;
    tick();
    tick();

    phase = "random";
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < SD; i++) segment[i] = CWL'($urandom_range(0, 7));
      rand_overlay();
      issue_start($urandom_range(0, 40));
      run_round(1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1);
      tick();
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
